// File: rtl/traffic_phase_scheduler.sv
// Two-approach right-of-way scheduler: tick prescaler, saturating phase timer
// and a six-phase light sequencer with latched approach requests.
module traffic_phase_scheduler #(
    parameter int PRESCALE  = 16,
    parameter int MIN_GREEN = 6,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 1
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       GND,
    input  logic       VDD,
    input  logic       CLR,
    input  logic       HOLD,
    input  logic       REQ_A,
    input  logic       REQ_B,
    output logic [1:0] LIGHT_A,
    output logic [1:0] LIGHT_B,
    output logic [2:0] PHASE,
    output logic       TICK,
    output logic       PEND_A,
    output logic       PEND_B
);

    // state  | meaning
    // A_GRN  | A green, B red (default owner)
    // A_YEL  | A yellow, B red
    // RED_AB | all red, clearing A before B
    // B_GRN  | B green, A red
    // B_YEL  | B yellow, A red
    // RED_BA | all red, clearing B before A
    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YEL  = 3'd1,
        RED_AB = 3'd2,
        B_GRN  = 3'd3,
        B_YEL  = 3'd4,
        RED_BA = 3'd5
    } phase_t;

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [3:0] MG_LAST  = 4'(MIN_GREEN - 1);
    localparam logic [3:0] YEL_LAST = 4'(YELLOW - 1);
    localparam logic [3:0] AR_LAST  = 4'(ALL_RED - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    timer_q, timer_d;
    phase_t        state_q, state_d, state_nxt;
    logic          pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic          exit_ok, legal;

    // Supply pins carry no logic.
    logic unused_supply;
    assign unused_supply = GND ^ VDD;

    assign TICK = (presc_q == PRE_LAST) && !HOLD;

    always_comb begin
        presc_d = presc_q;
        if (!HOLD) presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        state_nxt = state_q;
        exit_ok   = 1'b0;
        legal     = 1'b1;
        case (state_q)
            A_GRN:  begin exit_ok = (timer_q >= MG_LAST) && pend_b_q; state_nxt = A_YEL;  end
            A_YEL:  begin exit_ok = (timer_q == YEL_LAST);            state_nxt = RED_AB; end
            RED_AB: begin exit_ok = (timer_q == AR_LAST);             state_nxt = B_GRN;  end
            B_GRN:  begin exit_ok = (timer_q >= MG_LAST) && pend_a_q; state_nxt = B_YEL;  end
            B_YEL:  begin exit_ok = (timer_q == YEL_LAST);            state_nxt = RED_BA; end
            RED_BA: begin exit_ok = (timer_q == AR_LAST);             state_nxt = A_GRN;  end
            default: legal = 1'b0;
        endcase
        // Illegal codes recover on any edge, not only on ticks.
        if (!legal) begin
            state_d = A_GRN;
            timer_d = '0;
        end else if (TICK) begin
            if (exit_ok) begin
                state_d = state_nxt;
                timer_d = '0;
            end else if (timer_q != 4'hF) begin
                timer_d = timer_q + 4'd1;
            end
        end
    end

    // Entering a green clears that approach's latch, overriding a same-edge set.
    always_comb begin
        pend_a_d = pend_a_q | (REQ_A && (state_q != A_GRN));
        pend_b_d = pend_b_q | (REQ_B && (state_q != B_GRN));
        if (state_d == A_GRN && state_q != A_GRN) pend_a_d = 1'b0;
        if (state_d == B_GRN && state_q != B_GRN) pend_b_d = 1'b0;
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            presc_q  <= '0;
            timer_q  <= '0;
            state_q  <= A_GRN;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
        end else if (CLR) begin
            presc_q  <= '0;
            timer_q  <= '0;
            state_q  <= A_GRN;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            timer_q  <= timer_d;
            state_q  <= state_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
        end
    end

    always_comb begin
        LIGHT_A = 2'b00;
        LIGHT_B = 2'b00;
        case (state_q)
            A_GRN:   LIGHT_A = 2'b01;
            A_YEL:   LIGHT_A = 2'b10;
            B_GRN:   LIGHT_B = 2'b01;
            B_YEL:   LIGHT_B = 2'b10;
            default: ;
        endcase
    end

    assign PHASE  = state_q;
    assign PEND_A = pend_a_q;
    assign PEND_B = pend_b_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with PRESCALE=4, MIN_GREEN=2,
// YELLOW=2, ALL_RED=1; edge numbers count rising edges since the last realign.
module tb_traffic_phase_scheduler;

    logic       CK = 1'b0;
    logic       RN = 1'b1;
    logic       GND = 1'b0, VDD = 1'b1;
    logic       CLR = 1'b0, HOLD = 1'b0, REQ_A = 1'b0, REQ_B = 1'b0;
    logic [1:0] LIGHT_A, LIGHT_B;
    logic [2:0] PHASE;
    logic       TICK, PEND_A, PEND_B;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    traffic_phase_scheduler #(
        .PRESCALE(4), .MIN_GREEN(2), .YELLOW(2), .ALL_RED(1)
    ) dut (
        .CK(CK), .RN(RN), .GND(GND), .VDD(VDD), .CLR(CLR), .HOLD(HOLD),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .LIGHT_A(LIGHT_A), .LIGHT_B(LIGHT_B),
        .PHASE(PHASE), .TICK(TICK), .PEND_A(PEND_A), .PEND_B(PEND_B)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step_to(input int e);
        while (cyc < e) begin
            @(posedge CK);
            #1;
            cyc++;
        end
    endtask

    task automatic do_clear();
        CLR = 1'b1;
        @(posedge CK);
        #1;
        CLR = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] ph,
                             input logic [1:0] la, input logic [1:0] lb);
        chk({tag, "_phase"}, 8'(PHASE), 8'(ph));
        chk({tag, "_la"}, 8'(LIGHT_A), 8'(la));
        chk({tag, "_lb"}, 8'(LIGHT_B), 8'(lb));
    endtask

    // Both heads must never show a non-red aspect together.
    always @(negedge CK) chk("excl", 8'((LIGHT_A != 2'b00) && (LIGHT_B != 2'b00)), 8'd0);

    int alt_edge [7] = '{8, 16, 20, 28, 36, 40, 48};
    int alt_ph   [7] = '{1, 2, 3, 4, 5, 0, 1};

    initial begin
        #1 RN = 1'b0;
        #1;
        chk_state("rst", 3'd0, 2'b01, 2'b00);
        chk("rst_tick", 8'(TICK), 8'd0);
        chk("rst_pend", 8'({PEND_A, PEND_B}), 8'd0);
        @(negedge CK);
        @(negedge CK);
        RN = 1'b1;
        cyc = 0;

        // Idle: no requests, green stays on A, tick every 4th cycle.
        for (int i = 0; i < 40; i++) begin
            step_to(cyc + 1);
            chk("idle_tick", 8'(TICK), 8'((cyc % 4) == 3));
            chk("idle_phase", 8'(PHASE), 8'd0);
            chk("idle_la", 8'(LIGHT_A), 8'h1);
        end

        // Handover A -> B.
        do_clear();
        step_to(1);
        chk("ho_pendb_pre", 8'(PEND_B), 8'd0);
        REQ_B = 1'b1;
        step_to(2);
        REQ_B = 1'b0;
        chk("ho_pendb_set", 8'(PEND_B), 8'd1);
        step_to(7);
        chk_state("ho_e7", 3'd0, 2'b01, 2'b00);
        step_to(8);
        chk_state("ho_e8", 3'd1, 2'b10, 2'b00);
        step_to(15);
        chk_state("ho_e15", 3'd1, 2'b10, 2'b00);
        step_to(16);
        chk_state("ho_e16", 3'd2, 2'b00, 2'b00);
        step_to(19);
        chk("ho_pendb_hold", 8'(PEND_B), 8'd1);
        step_to(20);
        chk_state("ho_e20", 3'd3, 2'b00, 2'b01);
        chk("ho_pendb_clr", 8'(PEND_B), 8'd0);

        // Return B -> A with REQ_A held; clear wins on the A_GRN entry edge.
        REQ_A = 1'b1;
        step_to(21);
        chk("rt_penda_set", 8'(PEND_A), 8'd1);
        step_to(27);
        chk_state("rt_e27", 3'd3, 2'b00, 2'b01);
        step_to(28);
        chk_state("rt_e28", 3'd4, 2'b00, 2'b10);
        step_to(36);
        chk_state("rt_e36", 3'd5, 2'b00, 2'b00);
        step_to(39);
        chk("rt_penda_hold", 8'(PEND_A), 8'd1);
        step_to(40);
        chk_state("rt_e40", 3'd0, 2'b01, 2'b00);
        chk("rt_penda_clr", 8'(PEND_A), 8'd0);
        REQ_A = 1'b0;

        // HOLD over the tick at edge 48 shifts the A_YEL entry to edge 58.
        REQ_B = 1'b1;
        step_to(41);
        REQ_B = 1'b0;
        step_to(45);
        HOLD = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step_to(cyc + 1);
            chk("hold_tick", 8'(TICK), 8'd0);
            chk("hold_phase", 8'(PHASE), 8'd0);
        end
        HOLD = 1'b0;
        step_to(57);
        chk("hold_e57_phase", 8'(PHASE), 8'd0);
        chk("hold_e57_tick", 8'(TICK), 8'd1);
        step_to(58);
        chk_state("hold_e58", 3'd1, 2'b10, 2'b00);

        // CLR in A_YEL, landing on a tick edge.
        step_to(61);
        chk("clr_tick_pre", 8'(TICK), 8'd1);
        chk("clr_pendb_pre", 8'(PEND_B), 8'd1);
        do_clear();
        chk_state("clr", 3'd0, 2'b01, 2'b00);
        chk("clr_pend", 8'({PEND_A, PEND_B}), 8'd0);
        chk("clr_tick", 8'(TICK), 8'd0);
        step_to(2);
        chk("clr_tick_e2", 8'(TICK), 8'd0);
        step_to(3);
        chk("clr_tick_e3", 8'(TICK), 8'd1);

        // REQ_B high on the B_GRN entry edge leaves PEND_B clear.
        do_clear();
        REQ_B = 1'b1;
        step_to(2);
        REQ_B = 1'b0;
        step_to(19);
        REQ_B = 1'b1;
        step_to(20);
        REQ_B = 1'b0;
        chk_state("sim_e20", 3'd3, 2'b00, 2'b01);
        chk("sim_pendb", 8'(PEND_B), 8'd0);
        step_to(21);
        chk("sim_pendb_e21", 8'(PEND_B), 8'd0);

        // Asynchronous reset mid B_GRN, checked before any further edge.
        #3 RN = 1'b0;
        #1;
        chk_state("rn_async", 3'd0, 2'b01, 2'b00);
        chk("rn_pend", 8'({PEND_A, PEND_B}), 8'd0);

        // Both requests held: strict alternation.
        REQ_A = 1'b1;
        REQ_B = 1'b1;
        @(negedge CK);
        RN = 1'b1;
        cyc = 0;
        for (int i = 0; i < 7; i++) begin
            step_to(alt_edge[i] - 1);
            chk("alt_pre", 8'(PHASE), 8'((alt_ph[i] + 5) % 6));
            step_to(alt_edge[i]);
            chk("alt_post", 8'(PHASE), 8'(alt_ph[i]));
        end
        REQ_A = 1'b0;
        REQ_B = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
